// File: rtl/aes_stream_mode_ctrl.sv
// aes_stream_mode_ctrl: streaming wrapper around a stall-free pipelined AES core.
// Adds valid/ready backpressure, credit-based issue, an output FIFO, ECB/CTR
// modes and rekeying that waits for the pipeline and output FIFO to drain.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | unconfigured, waiting for the first cfg_load
//   ST_KEY   | key strobed to the core, waiting KEY_LAT cycles for round keys
//   ST_RUN   | accepting blocks while credits remain
//   ST_DRAIN | rekey requested, input closed until pipeline and FIFO are empty

// Small synchronous FIFO with first-word-fall-through head; shows zeros when empty.
module aes_smc_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = (count != '0) ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end
endmodule

module aes_stream_mode_ctrl #(
  parameter int DATA_W     = 128,
  parameter int KEY_LEN    = 128,
  parameter int FIFO_DEPTH = 16,
  parameter int KEY_LAT    = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic               cfg_mode,
  input  logic [KEY_LEN-1:0] cfg_key,
  input  logic [DATA_W-1:0]  cfg_iv,
  output logic               cfg_busy,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_W-1:0]  s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DATA_W-1:0]  m_data,
  output logic               core_key_valid,
  output logic [KEY_LEN-1:0] core_key,
  output logic               core_valid_in,
  output logic [DATA_W-1:0]  core_data_in,
  input  logic               core_valid_out,
  input  logic [DATA_W-1:0]  core_data_out,
  output logic [31:0]        blk_count,
  output logic               err_unexpected
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = (KEY_LAT > 1) ? $clog2(KEY_LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_KEY   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               load_cfg;
  logic [TMR_W-1:0]   key_tmr;
  logic               mode;
  logic [DATA_W-1:0]  ctr;
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W:0]     occupancy;
  logic               issue;
  logic               ret_ok;
  logic               ret_bad;
  logic               out_pop;
  logic [DATA_W-1:0]  out_push_data;
  logic [DATA_W-1:0]  out_head;
  logic [CNT_W-1:0]   out_count;
  logic [DATA_W-1:0]  side_head;
  logic [CNT_W-1:0]   side_count;
  logic               side_push;
  logic               side_pop;

  // Credits: every issued block already owns an output FIFO slot, so the
  // core can never return more than the FIFO can hold.
  assign occupancy     = {1'b0, inflight} + {1'b0, out_count};
  assign s_ready       = (state == ST_RUN) && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
  assign issue         = s_valid && s_ready;
  assign core_valid_in = issue;
  assign core_data_in  = mode ? ctr : s_data;
  assign cfg_busy      = (state == ST_KEY) || (state == ST_DRAIN);

  // A return with nothing outstanding is a core fault: flag it and drop the data.
  assign ret_ok  = core_valid_out && (inflight != '0);
  assign ret_bad = core_valid_out && (inflight == '0);

  assign side_push     = issue && mode;
  assign side_pop      = ret_ok && mode;
  assign out_push_data = mode ? (core_data_out ^ side_head) : core_data_out;

  assign m_valid = (out_count != '0);
  assign m_data  = out_head;
  assign out_pop = m_valid && m_ready;

  // Next-state and config-load decode.
  always_comb begin
    state_nxt = state;
    load_cfg  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_load) begin
          load_cfg  = 1'b1;
          state_nxt = ST_KEY;
        end
      end
      ST_KEY: begin
        if (key_tmr == '0) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (cfg_load) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Config is sampled here, not at the cfg_load that requested the drain.
        if ((inflight == '0) && (out_count == '0)) begin
          load_cfg  = 1'b1;
          state_nxt = ST_KEY;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Key strobe, latched config and the key-schedule down-counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_key_valid <= 1'b0;
      core_key       <= '0;
      mode           <= 1'b0;
      key_tmr        <= '0;
    end else begin
      core_key_valid <= load_cfg;
      if (load_cfg) begin
        core_key <= cfg_key;
        mode     <= cfg_mode;
        key_tmr  <= TMR_W'(KEY_LAT - 1);
      end else if ((state == ST_KEY) && (key_tmr != '0)) begin
        key_tmr <= key_tmr - TMR_W'(1);
      end
    end
  end

  // CTR counter block; full-width wrap with no stall at the rollover.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctr <= '0;
    end else if (load_cfg) begin
      ctr <= cfg_iv;
    end else if (issue && mode) begin
      ctr <= ctr + DATA_W'(1);
    end
  end

  // Blocks inside the core pipeline; a same-cycle issue and return cancel.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({issue, ret_ok})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Output handshake counter and sticky unexpected-return flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_count      <= '0;
      err_unexpected <= 1'b0;
    end else begin
      if (out_pop) blk_count <= blk_count + 32'd1;
      if (ret_bad) err_unexpected <= 1'b1;
    end
  end

  aes_smc_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_side_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (side_push),
    .push_data (s_data),
    .pop       (side_pop),
    .head      (side_head),
    .count     (side_count)
  );

  aes_smc_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (ret_ok),
    .push_data (out_push_data),
    .pop       (out_pop),
    .head      (out_head),
    .count     (out_count)
  );

  // Side FIFO occupancy mirrors inflight in CTR mode; kept only for debug visibility.
  logic side_count_unused;
  assign side_count_unused = ^side_count;
endmodule

// File: tb/tb_aes_stream_mode_ctrl.sv
// Directed bench for aes_stream_mode_ctrl. The core is a behavioural pipeline
// that returns known AES answers for the FIPS-197 / SP800-38A vectors and a
// keyed XOR for every other block.
module tb_aes_stream_mode_ctrl;
  localparam int DATA_W     = 128;
  localparam int KEY_LEN    = 128;
  localparam int FIFO_DEPTH = 16;
  localparam int KEY_LAT    = 12;
  localparam int CORE_LAT   = 6;

  localparam logic [127:0] MAGIC = 128'h5a5a_5a5a_a5a5_a5a5_3c3c_3c3c_c3c3_c3c3;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV2 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] IV3 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
  localparam logic [127:0] KS1 = 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
  localparam logic [127:0] KS2 = 128'h362b7c3c6773516318a077d7fc5073ae;
  localparam logic [127:0] P2A = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C2A = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] P2B = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C2B = 128'h9806f66b7970fdff8617187bb9fffdff;
  localparam logic [127:0] K3  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] K4  = 128'hdead_beef_0123_4567_89ab_cdef_fedc_ba98;
  localparam logic [127:0] K5  = 128'h0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0;
  localparam logic [127:0] Q0  = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
  localparam logic [127:0] Q1  = 128'hfedc_ba98_7654_3210_8899_aabb_ccdd_eeff;
  localparam logic [127:0] B3  = 128'h3000_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] B5  = 128'h5000_0000_0000_0000_0000_0000_0000_0100;
  localparam logic [127:0] PN  = 128'h7777_0000_1111_2222_3333_4444_5555_6666;

  logic               clk;
  logic               reset;
  logic               cfg_load;
  logic               cfg_mode;
  logic [KEY_LEN-1:0] cfg_key;
  logic [DATA_W-1:0]  cfg_iv;
  logic               cfg_busy;
  logic               s_valid;
  logic               s_ready;
  logic [DATA_W-1:0]  s_data;
  logic               m_valid;
  logic               m_ready;
  logic [DATA_W-1:0]  m_data;
  logic               core_key_valid;
  logic [KEY_LEN-1:0] core_key;
  logic               core_valid_in;
  logic [DATA_W-1:0]  core_data_in;
  logic               core_valid_out;
  logic [DATA_W-1:0]  core_data_out;
  logic [31:0]        blk_count;
  logic               err_unexpected;

  logic               inj_v;
  logic [127:0]       inj_d;
  logic               pv [CORE_LAT];
  logic [127:0]       pd [CORE_LAT];
  logic [127:0]       model_key;

  int n_cmp = 0;
  int n_bad = 0;
  int kv_pulses = 0;
  int key_age = 0;
  int early = 0;

  aes_stream_mode_ctrl #(
    .DATA_W(DATA_W), .KEY_LEN(KEY_LEN), .FIFO_DEPTH(FIFO_DEPTH), .KEY_LAT(KEY_LAT)
  ) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_mode(cfg_mode),
    .cfg_key(cfg_key), .cfg_iv(cfg_iv), .cfg_busy(cfg_busy),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .core_key_valid(core_key_valid), .core_key(core_key),
    .core_valid_in(core_valid_in), .core_data_in(core_data_in),
    .core_valid_out(core_valid_out), .core_data_out(core_data_out),
    .blk_count(blk_count), .err_unexpected(err_unexpected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d);
    if (k == K1 && d == P1)  return C1;
    if (k == K2 && d == IV2) return KS1;
    if (k == K2 && d == IV3) return KS2;
    return d ^ k ^ MAGIC;
  endfunction

  // Behavioural core: fixed-latency pipeline with no stall, key latched on strobe.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CORE_LAT; i++) pv[i] <= 1'b0;
      model_key <= '0;
    end else begin
      if (core_key_valid) model_key <= core_key;
      pv[0] <= core_valid_in;
      pd[0] <= core_fn(model_key, core_data_in);
      for (int i = 1; i < CORE_LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end
  assign core_valid_out = pv[CORE_LAT-1] | inj_v;
  assign core_data_out  = inj_v ? inj_d : pd[CORE_LAT-1];

  // Key-strobe counter and detector for blocks issued before round keys settle.
  always @(posedge clk) begin
    if (core_key_valid) begin
      kv_pulses <= kv_pulses + 1;
      key_age   <= 1;
    end else if (key_age < 1000) begin
      key_age <= key_age + 1;
    end
    if (core_valid_in && !core_key_valid && key_age < KEY_LAT) early <= early + 1;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_mvalid(input string tag);
    int n = 0;
    while (m_valid !== 1'b1 && n < 60) begin step(); n++; end
    if (m_valid !== 1'b1) chk(tag, 128'(m_valid), 128'd1);
  endtask

  // Pulse cfg_load, wait for the key strobe, then count cycles until s_ready.
  task automatic rekey(input string tag, input logic md, input logic [127:0] k,
                       input logic [127:0] iv, output int ready_cycles);
    int n = 0;
    cfg_mode = md; cfg_key = k; cfg_iv = iv; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    while (core_key_valid !== 1'b1 && n < 60) begin step(); n++; end
    chk({tag, "_key"}, core_key, k);
    chk({tag, "_busy"}, 128'(cfg_busy), 128'd1);
    ready_cycles = 0;
    while (s_ready !== 1'b1 && ready_cycles < 60) begin step(); ready_cycles++; end
  endtask

  initial begin
    int rc;
    int lat;
    int acc;
    int kv0;
    reset = 1'b1; cfg_load = 1'b0; cfg_mode = 1'b0; cfg_key = '0; cfg_iv = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0; inj_v = 1'b0; inj_d = '0;
    step(); step();
    chk("rst_s_ready", 128'(s_ready), 128'd0);
    chk("rst_m_valid", 128'(m_valid), 128'd0);
    chk("rst_m_data", m_data, 128'd0);
    chk("rst_core_key", core_key, 128'd0);
    chk("rst_kv_busy_err", {125'd0, core_key_valid, cfg_busy, err_unexpected}, 128'd0);
    chk("rst_blk_count", 128'(blk_count), 128'd0);
    reset = 1'b0;
    step();

    // ECB known answer and end-to-end latency
    rekey("ecb", 1'b0, K1, '0, rc);
    chk("key_lat_cycles", 128'(rc), 128'(KEY_LAT));
    s_valid = 1'b1; s_data = P1; m_ready = 1'b1;
    #1;
    chk("ecb_issue", 128'(core_valid_in), 128'd1);
    chk("ecb_core_in", core_data_in, P1);
    step();
    s_valid = 1'b0;
    lat = 1;
    while (m_valid !== 1'b1 && lat < 60) begin step(); lat++; end
    chk("ecb_latency", 128'(lat), 128'(CORE_LAT + 1));
    chk("ecb_m_data", m_data, C1);
    step();
    chk("ecb_blk_count", 128'(blk_count), 128'd1);

    // CTR known answers, two blocks back to back
    rekey("ctr", 1'b1, K2, IV2, rc);
    s_valid = 1'b1; s_data = P2A;
    #1;
    chk("ctr_core_in0", core_data_in, IV2);
    step();
    s_data = P2B;
    #1;
    chk("ctr_ready1", 128'(s_ready), 128'd1);
    chk("ctr_core_in1", core_data_in, IV3);
    step();
    s_valid = 1'b0;
    wait_mvalid("ctr_wait0");
    chk("ctr_out0", m_data, C2A);
    step();
    chk("ctr_out1", m_data, C2B);
    step();

    // CTR counter rollover from all-ones
    rekey("wrap", 1'b1, K3, '1, rc);
    s_valid = 1'b1; s_data = Q0;
    #1;
    chk("wrap_core_in0", core_data_in, '1);
    step();
    s_data = Q1;
    #1;
    chk("wrap_no_stall", 128'(s_ready), 128'd1);
    chk("wrap_core_in1", core_data_in, '0);
    step();
    s_valid = 1'b0;
    wait_mvalid("wrap_wait0");
    chk("wrap_out0", m_data, Q0 ^ core_fn(K3, '1));
    step();
    chk("wrap_out1", m_data, Q1 ^ core_fn(K3, '0));
    step();

    // Credit limit: sink stalled, exactly FIFO_DEPTH blocks accepted
    rekey("full", 1'b0, K4, '0, rc);
    m_ready = 1'b0; s_valid = 1'b1; acc = 0; s_data = B3;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (s_ready === 1'b1) acc++;
      step();
      s_data = B3 + 128'(acc);
    end
    s_valid = 1'b0;
    chk("full_accepted", 128'(acc), 128'(FIFO_DEPTH));
    chk("full_s_ready", 128'(s_ready), 128'd0);
    step();
    chk("full_head_stable", m_data, core_fn(K4, B3));
    m_ready = 1'b1;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      chk("full_order", m_data, core_fn(K4, B3 + 128'(i)));
      step();
      if (i == 0) chk("full_ready_after_pop", 128'(s_ready), 128'd1);
    end
    chk("full_empty", 128'(m_valid), 128'd0);

    // Rekey with five blocks in flight: drain under old key, then new key
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = B5 + 128'(i);
      step();
    end
    s_valid = 1'b0;
    cfg_key = K5; cfg_mode = 1'b0; cfg_load = 1'b1;
    kv0 = kv_pulses;
    step();
    cfg_load = 1'b0;
    s_valid = 1'b1; s_data = PN;
    #1;
    chk("drain_busy", 128'(cfg_busy), 128'd1);
    chk("drain_s_ready", 128'(s_ready), 128'd0);
    chk("drain_no_issue", 128'(core_valid_in), 128'd0);
    for (int i = 0; i < 5; i++) begin
      wait_mvalid("drain_wait");
      chk("drain_old_key", m_data, core_fn(K4, B5 + 128'(i)));
      chk("drain_no_early_kv", 128'(kv_pulses), 128'(kv0));
      step();
    end
    lat = 0;
    while (core_key_valid !== 1'b1 && lat < 60) begin step(); lat++; end
    chk("drain_new_key", core_key, K5);
    rc = 0;
    while (s_ready !== 1'b1 && rc < 60) begin step(); rc++; end
    chk("drain_key_lat", 128'(rc), 128'(KEY_LAT));
    chk("drain_kv_once", 128'(kv_pulses), 128'(kv0 + 1));
    #1;
    chk("drain_new_issue", 128'(core_valid_in), 128'd1);
    step();
    s_valid = 1'b0;
    wait_mvalid("drain_wait_new");
    chk("drain_new_data", m_data, core_fn(K5, PN));
    step();
    chk("blk_count_total", 128'(blk_count), 128'd27);

    // Unexpected core return, then reset mid-operation
    chk("err_clear", 128'(err_unexpected), 128'd0);
    inj_v = 1'b1; inj_d = 128'hbad0_bad0_bad0_bad0_bad0_bad0_bad0_bad0;
    step();
    inj_v = 1'b0;
    chk("err_set", 128'(err_unexpected), 128'd1);
    chk("err_no_mvalid", 128'(m_valid), 128'd0);
    step(); step();
    chk("err_sticky", 128'(err_unexpected), 128'd1);
    chk("err_still_empty", 128'(m_valid), 128'd0);
    m_ready = 1'b0; s_valid = 1'b1; s_data = Q0;
    step();
    s_data = Q1;
    step();
    s_valid = 1'b0;
    for (int i = 0; i < CORE_LAT + 3; i++) step();
    chk("pre_reset_queued", 128'(m_valid), 128'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_s_ready", 128'(s_ready), 128'd0);
    chk("rst2_m_data", m_data, 128'd0);
    chk("rst2_core_key", core_key, 128'd0);
    chk("rst2_flags", {124'd0, core_key_valid, cfg_busy, err_unexpected, m_valid}, 128'd0);
    chk("rst2_blk_count", 128'(blk_count), 128'd0);
    for (int i = 0; i < CORE_LAT + 3; i++) step();
    chk("rst2_discarded", 128'(m_valid), 128'd0);
    chk("no_early_issue", 128'(early), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
